// File: rtl/tec8_pkg.sv
// Shared constants for the TEC-8 datapath: ALU function codes, beat encodings
// and the timing-generator state type.
package tec8_pkg;

  // ALU S codes; meaning depends on M (arithmetic when M=0, logic when M=1)
  localparam logic [3:0] ALU_A     = 4'b0000;  // M=0: A + cin
  localparam logic [3:0] ALU_ADD   = 4'b1001;  // M=0: A + B + cin
  localparam logic [3:0] ALU_SUB   = 4'b0110;  // M=0: A + ~B + cin
  localparam logic [3:0] ALU_DEC   = 4'b1111;  // M=0: A + FF + cin
  localparam logic [3:0] ALU_B     = 4'b1010;  // M=1: B
  localparam logic [3:0] ALU_AND   = 4'b1011;  // M=1: A & B
  localparam logic [3:0] ALU_OR    = 4'b1110;  // M=1: A | B
  localparam logic [3:0] ALU_PASSA = 4'b1111;  // M=1: A
  localparam logic [3:0] ALU_NOTA  = 4'b0000;  // M=1: ~A
  localparam logic [3:0] ALU_XOR   = 4'b0110;  // M=1: A ^ B

  // One-hot beat encodings {W3,W2,W1}
  localparam logic [2:0] W1 = 3'b001;
  localparam logic [2:0] W2 = 3'b010;
  localparam logic [2:0] W3 = 3'b100;

  typedef enum logic {
    ST_HALT = 1'b0,
    ST_RUN  = 1'b1
  } tstate_e;

  // Beat sequencing at the end of a T3; SHORT dominates LONG when both are set
  function automatic logic [2:0] next_beat(input logic [2:0] w,
                                           input logic       short_req,
                                           input logic       long_req);
    logic [2:0] nb;
    nb = W1;
    case (w)
      W1:      nb = short_req ? W1 : W2;
      W2:      nb = long_req ? W3 : W1;
      default: nb = W1;
    endcase
    return nb;
  endfunction

endpackage

// File: rtl/tec8_alu.sv
// Combinational TEC-8 ALU. Arithmetic codes produce a DW+1 bit sum whose top
// bit is the carry; logic codes never produce a carry.
module tec8_alu
  import tec8_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [3:0]    s,
  input  logic          m,
  input  logic          cin,
  output logic [DW-1:0] f,
  output logic          cout
);

  logic [DW:0] sum;

  // Select the function; unsupported codes yield zero with no carry
  always_comb begin
    sum  = '0;
    f    = '0;
    cout = 1'b0;
    if (!m) begin
      case (s)
        ALU_A:   sum = {1'b0, a} + {{DW{1'b0}}, cin};
        ALU_ADD: sum = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
        ALU_SUB: sum = {1'b0, a} + {1'b0, ~b} + {{DW{1'b0}}, cin};
        ALU_DEC: sum = {1'b0, a} + {1'b0, {DW{1'b1}}} + {{DW{1'b0}}, cin};
        default: sum = '0;
      endcase
      f    = sum[DW-1:0];
      cout = sum[DW];
    end else begin
      case (s)
        ALU_B:     f = b;
        ALU_AND:   f = a & b;
        ALU_OR:    f = a | b;
        ALU_PASSA: f = a;
        ALU_NOTA:  f = ~a;
        ALU_XOR:   f = a ^ b;
        default:   f = '0;
      endcase
    end
  end

endmodule

// File: rtl/tec8_datapath.sv
// TEC-8 datapath and beat/timing generator. Executes the hardwired
// controller's strobes once per beat, at the clock edge that ends T3.
module tec8_datapath
  import tec8_pkg::*;
#(
  parameter int BEAT_CYCLES = 4,
  parameter int DW          = 8
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          QD,
  input  logic [DW-1:0] SWD,
  input  logic          SELCTL,
  input  logic          DRW,
  input  logic          LPC,
  input  logic          PCINC,
  input  logic          PCADD,
  input  logic          LAR,
  input  logic          ARINC,
  input  logic          LIR,
  input  logic          LDZ,
  input  logic          LDC,
  input  logic          CIN,
  input  logic          M,
  input  logic          MEMW,
  input  logic          ABUS,
  input  logic          SBUS,
  input  logic          MBUS,
  input  logic          STOP,
  input  logic          SHORT,
  input  logic          LONG,
  input  logic [3:0]    S,
  input  logic [3:0]    SEL,
  output logic [2:0]    W,
  output logic          T3,
  output logic [DW-1:0] IR,
  output logic          C,
  output logic          Z,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] r0,
  output logic [DW-1:0] r1,
  output logic [DW-1:0] r2,
  output logic [DW-1:0] r3,
  output logic [DW-1:0] pc,
  output logic [DW-1:0] ar,
  output logic [DW-1:0] dbus,
  output logic          halted,
  output logic          bus_conflict
);

  localparam int CW = (BEAT_CYCLES > 2) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BEAT_CYCLES - 1);

  // Timing generator state
  tstate_e       state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    w_q;
  logic          qd_q;
  logic          qd_rise;
  logic          t3;

  // Architectural state
  logic [DW-1:0] rf_q [4];
  logic [DW-1:0] pc_q;
  logic [DW-1:0] ar_q;
  logic [DW-1:0] ir_q;
  logic          c_q;
  logic          z_q;
  logic          bc_q;

  // Datapath nets
  logic [1:0]        idx_a;
  logic [1:0]        idx_b;
  logic [DW-1:0]     op_a;
  logic [DW-1:0]     op_b;
  logic [DW-1:0]     alu_f;
  logic              alu_cout;
  logic [DW-1:0]     bus_val;
  logic [1:0]        en_cnt;
  logic signed [DW-1:0] pc_off;
  logic [DW-1:0]     pc_step;
  logic [DW-1:0]     pc_d;
  logic [DW-1:0]     ar_d;

  assign qd_rise = QD & ~qd_q;
  assign t3      = (state_q == ST_RUN) && (cnt_q == CNT_LAST);

  // Beat timing: HALT waits for a start edge, RUN counts cycles within a beat
  always_ff @(posedge CLK) begin
    qd_q <= QD;
    if (CLR) begin
      state_q <= ST_HALT;
      cnt_q   <= '0;
      w_q     <= W1;
    end else begin
      case (state_q)
        ST_HALT: begin
          if (qd_rise) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
          end
        end
        ST_RUN: begin
          if (t3) begin
            cnt_q <= '0;
            w_q   <= next_beat(w_q, SHORT, LONG);
            if (STOP) begin
              state_q <= ST_HALT;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= ST_HALT;
      endcase
    end
  end

  // Console select overrides the instruction's register fields
  assign idx_a = SELCTL ? SEL[3:2] : ir_q[3:2];
  assign idx_b = SELCTL ? SEL[1:0] : ir_q[1:0];
  assign op_a  = rf_q[idx_a];
  assign op_b  = rf_q[idx_b];

  tec8_alu #(
    .DW (DW)
  ) u_alu (
    .a    (op_a),
    .b    (op_b),
    .s    (S),
    .m    (M),
    .cin  (~CIN),
    .f    (alu_f),
    .cout (alu_cout)
  );

  // Fixed-priority bus source: ALU, then memory, then console switches
  always_comb begin
    bus_val = '0;
    if (ABUS) begin
      bus_val = alu_f;
    end else if (MBUS) begin
      bus_val = mem_rdata;
    end else if (SBUS) begin
      bus_val = SWD;
    end
  end

  assign en_cnt = 2'(ABUS) + 2'(MBUS) + 2'(SBUS);

  // PC branch offset is the signed low nibble of IR; PCADD and PCINC compose
  assign pc_off  = {{(DW-4){ir_q[3]}}, ir_q[3:0]};
  assign pc_step = (PCADD ? pc_off : '0) + (PCINC ? DW'(1) : '0);

  // Next PC and AR; bus loads take priority over increments
  always_comb begin
    pc_d = pc_q;
    if (LPC) begin
      pc_d = bus_val;
    end else if (PCADD || PCINC) begin
      pc_d = pc_q + pc_step;
    end
    ar_d = ar_q;
    if (LAR) begin
      ar_d = bus_val;
    end else if (ARINC) begin
      ar_d = ar_q + DW'(1);
    end
  end

  // Register writes happen only at the edge closing a running T3 cycle
  always_ff @(posedge CLK) begin
    if (CLR) begin
      for (int i = 0; i < 4; i++) begin
        rf_q[i] <= '0;
      end
      pc_q <= '0;
      ar_q <= '0;
      ir_q <= '0;
      c_q  <= 1'b0;
      z_q  <= 1'b0;
      bc_q <= 1'b0;
    end else if (t3) begin
      if (DRW) begin
        rf_q[idx_a] <= bus_val;
      end
      pc_q <= pc_d;
      ar_q <= ar_d;
      if (LIR) begin
        ir_q <= mem_rdata;
      end
      if (LDC) begin
        c_q <= alu_cout;
      end
      if (LDZ) begin
        z_q <= (alu_f == '0);
      end
      if (en_cnt > 2'd1) begin
        bc_q <= 1'b1;
      end
    end
  end

  // Instruction fetch uses PC, all other memory traffic uses AR
  assign mem_addr  = LIR ? pc_q : ar_q;
  assign mem_wdata = bus_val;
  assign mem_we    = MEMW & t3;

  assign W            = w_q;
  assign T3           = t3;
  assign IR           = ir_q;
  assign C            = c_q;
  assign Z            = z_q;
  assign r0           = rf_q[0];
  assign r1           = rf_q[1];
  assign r2           = rf_q[2];
  assign r3           = rf_q[3];
  assign pc           = pc_q;
  assign ar           = ar_q;
  assign dbus         = bus_val;
  assign halted       = (state_q == ST_HALT);
  assign bus_conflict = bc_q;

endmodule

// File: tb/tb_tec8_datapath.sv
// Directed bench for tec8_datapath: a table of one-beat vectors with
// hand-computed register state, plus hand sequences for start-up, HALT,
// resume, bus contention and reset in the middle of a beat.
`timescale 1ns/1ps
module tb_tec8_datapath;

  localparam int BC = 4;

  localparam int C_SELCTL = 1 << 0;
  localparam int C_DRW    = 1 << 1;
  localparam int C_LPC    = 1 << 2;
  localparam int C_PCINC  = 1 << 3;
  localparam int C_PCADD  = 1 << 4;
  localparam int C_LAR    = 1 << 5;
  localparam int C_ARINC  = 1 << 6;
  localparam int C_LIR    = 1 << 7;
  localparam int C_LDZ    = 1 << 8;
  localparam int C_LDC    = 1 << 9;
  localparam int C_CIN    = 1 << 10;
  localparam int C_M      = 1 << 11;
  localparam int C_MEMW   = 1 << 12;
  localparam int C_ABUS   = 1 << 13;
  localparam int C_SBUS   = 1 << 14;
  localparam int C_MBUS   = 1 << 15;
  localparam int C_STOP   = 1 << 16;
  localparam int C_SHORT  = 1 << 17;
  localparam int C_LONG   = 1 << 18;

  logic       CLK = 1'b0;
  logic       CLR, QD;
  logic [7:0] SWD;
  logic       SELCTL, DRW, LPC, PCINC, PCADD, LAR, ARINC, LIR, LDZ, LDC;
  logic       CIN, M, MEMW, ABUS, SBUS, MBUS, STOP, SHORT, LONG;
  logic [3:0] S, SEL;
  logic [2:0] W;
  logic       T3, C, Z, mem_we, halted, bus_conflict;
  logic [7:0] IR, mem_addr, mem_wdata, mem_rdata;
  logic [7:0] r0, r1, r2, r3, pc, ar, dbus;

  logic [7:0] ram [256];
  int         checks = 0;
  int         fails = 0;
  int         we_cnt = 0;
  logic [7:0] we_addr = 8'h00;
  logic [7:0] we_data = 8'h00;

  typedef struct {
    int         ctl;
    logic [3:0] s;
    logic [3:0] sel;
    logic [7:0] swd;
    logic [7:0] r0, r1, r2, r3, pc, ar, ir;
    logic       c, z;
    logic [2:0] w;
    logic       hlt, bc;
  } vec_t;

  vec_t tbl[$];

  tec8_datapath #(.BEAT_CYCLES(BC), .DW(8)) dut (
    .CLK(CLK), .CLR(CLR), .QD(QD), .SWD(SWD),
    .SELCTL(SELCTL), .DRW(DRW), .LPC(LPC), .PCINC(PCINC), .PCADD(PCADD),
    .LAR(LAR), .ARINC(ARINC), .LIR(LIR), .LDZ(LDZ), .LDC(LDC), .CIN(CIN),
    .M(M), .MEMW(MEMW), .ABUS(ABUS), .SBUS(SBUS), .MBUS(MBUS), .STOP(STOP),
    .SHORT(SHORT), .LONG(LONG), .S(S), .SEL(SEL),
    .W(W), .T3(T3), .IR(IR), .C(C), .Z(Z),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .pc(pc), .ar(ar), .dbus(dbus),
    .halted(halted), .bus_conflict(bus_conflict)
  );

  always #5 CLK = ~CLK;

  // Synchronous-write RAM with combinational read; two bytes preloaded on reset
  assign mem_rdata = ram[mem_addr];
  always @(posedge CLK) begin
    if (CLR) begin
      ram[8'h00] <= 8'h14;
      ram[8'h10] <= 8'h1E;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
  end

  // Record every write strobe seen mid-cycle
  always @(negedge CLK) begin
    if (mem_we) begin
      we_cnt  <= we_cnt + 1;
      we_addr <= mem_addr;
      we_data <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input int ctl, input logic [3:0] s, input logic [3:0] sel,
                     input logic [7:0] swd, input logic [7:0] e0, input logic [7:0] e1,
                     input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] epc,
                     input logic [7:0] ear, input logic [7:0] eir, input logic ec,
                     input logic ez, input logic [2:0] ew, input logic eh, input logic eb);
    vec_t v;
    v.ctl = ctl; v.s = s; v.sel = sel; v.swd = swd;
    v.r0 = e0; v.r1 = e1; v.r2 = e2; v.r3 = e3;
    v.pc = epc; v.ar = ear; v.ir = eir; v.c = ec; v.z = ez;
    v.w = ew; v.hlt = eh; v.bc = eb;
    tbl.push_back(v);
  endtask

  task automatic drive(input int ctl, input logic [3:0] s, input logic [3:0] sel,
                       input logic [7:0] swd);
    SELCTL = (ctl & C_SELCTL) != 0;
    DRW    = (ctl & C_DRW) != 0;
    LPC    = (ctl & C_LPC) != 0;
    PCINC  = (ctl & C_PCINC) != 0;
    PCADD  = (ctl & C_PCADD) != 0;
    LAR    = (ctl & C_LAR) != 0;
    ARINC  = (ctl & C_ARINC) != 0;
    LIR    = (ctl & C_LIR) != 0;
    LDZ    = (ctl & C_LDZ) != 0;
    LDC    = (ctl & C_LDC) != 0;
    CIN    = (ctl & C_CIN) != 0;
    M      = (ctl & C_M) != 0;
    MEMW   = (ctl & C_MEMW) != 0;
    ABUS   = (ctl & C_ABUS) != 0;
    SBUS   = (ctl & C_SBUS) != 0;
    MBUS   = (ctl & C_MBUS) != 0;
    STOP   = (ctl & C_STOP) != 0;
    SHORT  = (ctl & C_SHORT) != 0;
    LONG   = (ctl & C_LONG) != 0;
    S      = s;
    SEL    = sel;
    SWD    = swd;
  endtask

  // Wait (bounded) for the T3 cycle, sampled mid-cycle
  task automatic wait_t3(input string name);
    int n;
    n = 0;
    @(negedge CLK);
    while (T3 !== 1'b1 && n < 4 * BC) begin
      @(negedge CLK);
      n++;
    end
    if (T3 !== 1'b1) begin
      checks++;
      fails++;
      $display("FAIL %s_t3_timeout: got T3=%0b expected 1 within %0d cycles", name, T3, 4 * BC);
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t  v;
    string p;
    v = tbl[idx];
    p = $sformatf("v%0d", idx);
    drive(v.ctl, v.s, v.sel, v.swd);
    wait_t3(p);
    @(posedge CLK);
    #1;
    drive(0, 4'h0, 4'h0, 8'h00);
    chk({p, "_r0"}, r0, v.r0);
    chk({p, "_r1"}, r1, v.r1);
    chk({p, "_r2"}, r2, v.r2);
    chk({p, "_r3"}, r3, v.r3);
    chk({p, "_pc"}, pc, v.pc);
    chk({p, "_ar"}, ar, v.ar);
    chk({p, "_ir"}, IR, v.ir);
    chk({p, "_c"}, C, v.c);
    chk({p, "_z"}, Z, v.z);
    chk({p, "_w"}, W, v.w);
    chk({p, "_halted"}, halted, v.hlt);
    chk({p, "_busconf"}, bus_conflict, v.bc);
  endtask

  task automatic pulse_qd();
    @(negedge CLK);
    QD = 1'b1;
    @(negedge CLK);
    QD = 1'b0;
  endtask

  initial begin
    //   ctl                                      s     sel   swd    r0     r1     r2     r3     pc     ar     ir     c     z     w       h     bc
    add(C_SELCTL|C_SBUS|C_DRW,                    4'h0, 4'hC, 8'h5A, 8'h01 & 8'h00, 8'h00, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0);
    add(C_SELCTL|C_SBUS|C_DRW,                    4'h0, 4'h4, 8'hA5, 8'h00, 8'hA5, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0);
    add(C_SELCTL|C_SBUS|C_DRW,                    4'h0, 4'h0, 8'h01, 8'h01, 8'hA5, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0);
    add(C_SELCTL|C_SBUS|C_DRW,                    4'h0, 4'h4, 8'hFF, 8'h01, 8'hFF, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0);
    add(C_LIR|C_PCINC,                            4'h0, 4'h0, 8'h00, 8'h01, 8'hFF, 8'h00, 8'h5A, 8'h01, 8'h00, 8'h14, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0);
    add(C_CIN|C_ABUS|C_DRW|C_LDC|C_LDZ,           4'h9, 4'h0, 8'h00, 8'h01, 8'h00, 8'h00, 8'h5A, 8'h01, 8'h00, 8'h14, 1'b1, 1'b1, 3'b001, 1'b0, 1'b0);
    add(C_ABUS|C_DRW|C_LDC|C_LDZ,                 4'h6, 4'h0, 8'h00, 8'h01, 8'hFF, 8'h00, 8'h5A, 8'h01, 8'h00, 8'h14, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0);
    add(C_M|C_ABUS|C_DRW|C_LDZ|C_LONG,            4'hB, 4'h0, 8'h00, 8'h01, 8'h01, 8'h00, 8'h5A, 8'h01, 8'h00, 8'h14, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0);
    add(C_M|C_ABUS|C_DRW|C_LDZ,                   4'h6, 4'h0, 8'h00, 8'h01, 8'h00, 8'h00, 8'h5A, 8'h01, 8'h00, 8'h14, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0);
    add(C_SHORT|C_LONG|C_SELCTL|C_SBUS|C_DRW,     4'h0, 4'h8, 8'h3C, 8'h01, 8'h00, 8'h3C, 8'h5A, 8'h01, 8'h00, 8'h14, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0);
    add(C_M|C_SELCTL|C_ABUS|C_DRW,                4'hE, 4'hB, 8'h00, 8'h01, 8'h00, 8'h7E, 8'h5A, 8'h01, 8'h00, 8'h14, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0);
    add(C_CIN|C_SELCTL|C_ABUS|C_DRW|C_LDC,        4'hF, 4'hC, 8'h00, 8'h01, 8'h00, 8'h7E, 8'h59, 8'h01, 8'h00, 8'h14, 1'b1, 1'b1, 3'b001, 1'b0, 1'b0);
    add(C_M|C_SELCTL|C_ABUS|C_LAR|C_LDZ,          4'h0, 4'h0, 8'h00, 8'h01, 8'h00, 8'h7E, 8'h59, 8'h01, 8'hFE, 8'h14, 1'b1, 1'b0, 3'b010, 1'b0, 1'b0);
    add(C_ARINC,                                  4'h0, 4'h0, 8'h00, 8'h01, 8'h00, 8'h7E, 8'h59, 8'h01, 8'hFF, 8'h14, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0);
    add(C_ARINC,                                  4'h0, 4'h0, 8'h00, 8'h01, 8'h00, 8'h7E, 8'h59, 8'h01, 8'h00, 8'h14, 1'b1, 1'b0, 3'b010, 1'b0, 1'b0);
    add(C_SELCTL|C_ABUS|C_LPC,                    4'h0, 4'h8, 8'h00, 8'h01, 8'h00, 8'h7E, 8'h59, 8'h7F, 8'h00, 8'h14, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0);
    add(C_SBUS|C_LPC|C_PCINC,                     4'h0, 4'h0, 8'h10, 8'h01, 8'h00, 8'h7E, 8'h59, 8'h10, 8'h00, 8'h14, 1'b1, 1'b0, 3'b010, 1'b0, 1'b0);
    add(C_LIR,                                    4'h0, 4'h0, 8'h00, 8'h01, 8'h00, 8'h7E, 8'h59, 8'h10, 8'h00, 8'h1E, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0);
    add(C_PCADD,                                  4'h0, 4'h0, 8'h00, 8'h01, 8'h00, 8'h7E, 8'h59, 8'h0E, 8'h00, 8'h1E, 1'b1, 1'b0, 3'b010, 1'b0, 1'b0);
    add(C_PCADD|C_PCINC,                          4'h0, 4'h0, 8'h00, 8'h01, 8'h00, 8'h7E, 8'h59, 8'h0D, 8'h00, 8'h1E, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0);
    add(C_SBUS|C_LPC,                             4'h0, 4'h0, 8'hFF, 8'h01, 8'h00, 8'h7E, 8'h59, 8'hFF, 8'h00, 8'h1E, 1'b1, 1'b0, 3'b010, 1'b0, 1'b0);
    add(C_PCINC,                                  4'h0, 4'h0, 8'h00, 8'h01, 8'h00, 8'h7E, 8'h59, 8'h00, 8'h00, 8'h1E, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0);
    add(C_SELCTL|C_MBUS|C_DRW,                    4'h0, 4'h0, 8'h00, 8'h14, 8'h00, 8'h7E, 8'h59, 8'h00, 8'h00, 8'h1E, 1'b1, 1'b0, 3'b010, 1'b0, 1'b0);
    add(C_SBUS|C_LAR,                             4'h0, 4'h0, 8'h20, 8'h14, 8'h00, 8'h7E, 8'h59, 8'h00, 8'h20, 8'h1E, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0);
    add(C_SBUS|C_MEMW|C_ARINC,                    4'h0, 4'h0, 8'h77, 8'h14, 8'h00, 8'h7E, 8'h59, 8'h00, 8'h21, 8'h1E, 1'b1, 1'b0, 3'b010, 1'b0, 1'b0);
    add(C_STOP|C_SELCTL|C_SBUS|C_DRW,             4'h0, 4'h4, 8'hC3, 8'h14, 8'hC3, 8'h7E, 8'h59, 8'h00, 8'h21, 8'h1E, 1'b1, 1'b0, 3'b001, 1'b1, 1'b0);
    add(C_SELCTL|C_M|C_ABUS|C_SBUS|C_DRW,         4'hA, 4'h3, 8'hAA, 8'h59, 8'hC3, 8'h7E, 8'h59, 8'h00, 8'h21, 8'h1E, 1'b1, 1'b0, 3'b010, 1'b0, 1'b1);

    // Reset held for two cycles
    QD  = 1'b0;
    CLR = 1'b1;
    drive(0, 4'h0, 4'h0, 8'h00);
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_w", W, 3'b001);
    chk("rst_t3", T3, 1'b0);
    chk("rst_halted", halted, 1'b1);
    chk("rst_regs", {r0, r1, r2, r3}, 32'h0);
    chk("rst_pc_ar_ir", {pc, ar, IR}, 24'h0);
    chk("rst_flags", {C, Z, bus_conflict, mem_we}, 4'h0);
    CLR = 1'b0;

    // Halted after reset: beat frozen until a start edge
    repeat (3) @(posedge CLK);
    #1;
    chk("idle_w", W, 3'b001);
    chk("idle_t3", T3, 1'b0);
    chk("idle_halted", halted, 1'b1);

    // Start: two idle beats, T3 only in the last cycle of each
    pulse_qd();
    chk("start_halted", halted, 1'b0);
    for (int k = 0; k < 2 * BC; k++) begin
      chk($sformatf("start_t3_c%0d", k), T3, (k % BC) == BC - 1);
      chk($sformatf("start_w_c%0d", k), W, (k < BC) ? 3'b001 : 3'b010);
      @(negedge CLK);
    end

    for (int i = 0; i < 25; i++) begin
      run_vec(i);
    end
    chk("memw_count", we_cnt, 1);
    chk("memw_addr", we_addr, 8'h20);
    chk("memw_data", we_data, 8'h77);
    chk("memw_ram", ram[8'h20], 8'h77);
    chk("memw_off", mem_we, 1'b0);

    // STOP: write completes, then the machine freezes with W1 pending
    run_vec(25);
    drive(C_PCINC|C_SBUS|C_DRW|C_MEMW|C_LDC, 4'h0, 4'h0, 8'hFF);
    for (int k = 0; k < 2 * BC; k++) begin
      @(negedge CLK);
      chk($sformatf("halt_t3_c%0d", k), T3, 1'b0);
      chk($sformatf("halt_w_c%0d", k), W, 3'b001);
    end
    drive(0, 4'h0, 4'h0, 8'h00);
    chk("halt_pc", pc, 8'h00);
    chk("halt_r0", r0, 8'h14);
    chk("halt_c", C, 1'b1);
    chk("halt_memw_count", we_cnt, 1);
    chk("halt_still", halted, 1'b1);

    // Resume, then ABUS and SBUS together: ALU wins, conflict latches
    pulse_qd();
    chk("resume_halted", halted, 1'b0);
    run_vec(26);

    // Reset landing on a T3 cycle discards that beat's writes
    drive(C_SELCTL|C_SBUS|C_DRW|C_LPC, 4'h0, 4'h0, 8'hFF);
    wait_t3("abort");
    CLR = 1'b1;
    @(posedge CLK);
    #1;
    CLR = 1'b0;
    drive(0, 4'h0, 4'h0, 8'h00);
    chk("abort_r0", r0, 8'h00);
    chk("abort_pc", pc, 8'h00);
    chk("abort_w", W, 3'b001);
    chk("abort_halted", halted, 1'b1);
    chk("abort_busconf", bus_conflict, 1'b0);
    chk("abort_t3", T3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
